// File: rtl/alpu_exec_unit_if.sv
// Bundles the instruction handshake, external cache write port, read-out port
// and result report of alpu_exec_unit.
interface alpu_exec_unit_if #(
    parameter int REG_WIDTH  = 4,
    parameter int ADDR_WIDTH = 2
);
    logic                  instr_valid_i;
    logic                  instr_ready_o;
    logic [3:0]            instr_i;
    logic [ADDR_WIDTH-1:0] op1_i;
    logic [ADDR_WIDTH-1:0] op2_i;
    logic [ADDR_WIDTH-1:0] opd_i;
    logic                  ext_we_i;
    logic [ADDR_WIDTH-1:0] ext_addr_i;
    logic [REG_WIDTH-1:0]  ext_wdata_i;
    logic                  ext_wack_o;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic [REG_WIDTH-1:0]  rd_data_o;
    logic                  res_valid_o;
    logic [REG_WIDTH-1:0]  res_data_o;
    logic                  res_cout_o;
    logic                  err_o;

    modport master (
        output instr_valid_i, instr_i, op1_i, op2_i, opd_i,
        output ext_we_i, ext_addr_i, ext_wdata_i, rd_addr_i,
        input  instr_ready_o, ext_wack_o, rd_data_o,
        input  res_valid_o, res_data_o, res_cout_o, err_o
    );

    modport slave (
        input  instr_valid_i, instr_i, op1_i, op2_i, opd_i,
        input  ext_we_i, ext_addr_i, ext_wdata_i, rd_addr_i,
        output instr_ready_o, ext_wack_o, rd_data_o,
        output res_valid_o, res_data_o, res_cout_o, err_o
    );
endinterface

// File: rtl/alpu_exec_unit.sv
// Three-cycle ALU execution unit operating on a small register cache with a
// carry flag, an external write port and a registered read-out port.
module alpu_exec_unit #(
    parameter int REG_WIDTH  = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    alpu_exec_unit_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                state_q, state_d;
    logic [REG_WIDTH-1:0]  cache_q [DEPTH];
    logic                  carry_q;
    logic [3:0]            instr_q;
    logic [ADDR_WIDTH-1:0] op1_q, op2_q, opd_q;
    logic                  res_valid_q, res_cout_q, err_q, ext_wack_q;
    logic [REG_WIDTH-1:0]  res_data_q, rd_data_q;

    logic                  instr_ready;
    logic                  accept;
    logic [REG_WIDTH-1:0]  op_a, op_b, add_b, alu_res;
    logic                  add_cin, alu_cout, alu_err, alu_we, alu_cwe;
    logic [REG_WIDTH:0]    sum;
    logic                  wb_en, wb_clash, ext_en;

    assign instr_ready = (state_q == IDLE) && !reset;
    assign accept      = bus.instr_valid_i && instr_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_a     = cache_q[op1_q];
        op_b     = cache_q[op2_q];
        // Opcodes 0-3 share one adder: bit1 inverts B, bit0 selects carry-in
        add_b    = instr_q[1] ? ~op_b : op_b;
        add_cin  = instr_q[0] ? carry_q : instr_q[1];
        sum      = {1'b0, op_a} + {1'b0, add_b} + {{REG_WIDTH{1'b0}}, add_cin};
        alu_res  = '0;
        alu_cout = carry_q;
        alu_err  = 1'b0;
        alu_we   = 1'b1;
        alu_cwe  = 1'b0;
        case (instr_q)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                alu_res  = sum[REG_WIDTH-1:0];
                alu_cout = sum[REG_WIDTH];
                alu_cwe  = 1'b1;
            end
            4'd4: alu_res = op_a & op_b;
            4'd5: alu_res = op_a | op_b;
            4'd6: alu_res = op_a ^ op_b;
            4'd7: alu_res = ~op_a;
            4'd8: alu_res = op_a;
            4'd9: begin
                alu_res  = {op_a[REG_WIDTH-2:0], 1'b0};
                alu_cout = op_a[REG_WIDTH-1];
                alu_cwe  = 1'b1;
            end
            4'd10: begin
                alu_res  = {1'b0, op_a[REG_WIDTH-1:1]};
                alu_cout = op_a[0];
                alu_cwe  = 1'b1;
            end
            default: begin
                alu_err = 1'b1;
                alu_we  = 1'b0;
            end
        endcase
    end

    // A writeback to the same address on the same edge overrides the external write
    assign wb_en    = (state_q == EXEC) && alu_we;
    assign wb_clash = wb_en && (opd_q == bus.ext_addr_i);
    assign ext_en   = bus.ext_we_i && !wb_clash;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            for (int unsigned i = 0; i < DEPTH; i++) cache_q[i] <= '0;
            carry_q     <= 1'b0;
            instr_q     <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            opd_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cout_q  <= 1'b0;
            err_q       <= 1'b0;
            ext_wack_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_data_q   <= cache_q[bus.rd_addr_i];
            ext_wack_q  <= ext_en;
            res_valid_q <= (state_q == EXEC);
            if (ext_en) cache_q[bus.ext_addr_i] <= bus.ext_wdata_i;
            if (wb_en) cache_q[opd_q] <= alu_res;
            if ((state_q == EXEC) && alu_cwe) carry_q <= alu_cout;
            if (state_q == EXEC) begin
                res_data_q <= alu_res;
                res_cout_q <= alu_cout;
                err_q      <= alu_err;
            end
            if (accept) begin
                instr_q <= bus.instr_i;
                op1_q   <= bus.op1_i;
                op2_q   <= bus.op2_i;
                opd_q   <= bus.opd_i;
            end
        end
    end

    assign bus.instr_ready_o = instr_ready;
    assign bus.res_valid_o   = res_valid_q;
    assign bus.res_data_o    = res_data_q;
    assign bus.res_cout_o    = res_cout_q;
    assign bus.err_o         = err_q;
    assign bus.ext_wack_o    = ext_wack_q;
    assign bus.rd_data_o     = rd_data_q;
endmodule
